// File: rtl/ro_pair_comparator_if.sv
// Response channel of the RO-pair PUF comparator: valid/ready handshake plus result payload.
`timescale 1ns/1ps
interface ro_pair_comparator_if #(
  parameter int unsigned CNT_W = 16
);
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_bit;
  logic             resp_tie;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (
    output resp_valid,
    output resp_bit,
    output resp_tie,
    output cnt_a,
    output cnt_b,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_bit,
    input  resp_tie,
    input  cnt_a,
    input  cnt_b,
    output resp_ready
  );
endinterface

// File: rtl/ro_pair_comparator.sv
// Ring-oscillator pair comparator: enables both ROs, lets them settle, counts rising edges of each
// over a fixed window and reports which oscillator was faster as a one-bit PUF response.
`timescale 1ns/1ps
module ro_pair_comparator #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned WINDOW = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ro_a,
  input  logic                  ro_b,
  output logic                  ro_enable,
  output logic                  busy,
  ro_pair_comparator_if.master  resp
);

  localparam int unsigned PHASE_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned TMR_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] r_out_cnt_a;
  logic [CNT_W-1:0] r_out_cnt_b;
  logic             r_resp_bit;
  logic             r_resp_tie;
  logic             r_resp_valid;
  logic             r_ro_enable;
  logic             r_busy;

  logic [1:0]       r_sync_a;
  logic [1:0]       r_sync_b;
  logic             r_prev_a;
  logic             r_prev_b;
  logic             w_rise_a;
  logic             w_rise_b;

  // Two-flop synchronizers followed by an edge register per oscillator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_a <= 2'b00;
      r_sync_b <= 2'b00;
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[0], ro_a};
      r_sync_b <= {r_sync_b[0], ro_b};
      r_prev_a <= r_sync_a[1];
      r_prev_b <= r_sync_b[1];
    end
  end

  assign w_rise_a = r_sync_a[1] & ~r_prev_a;
  assign w_rise_b = r_sync_b[1] & ~r_prev_b;

  // Measurement sequencer; the result is latched one cycle after HOLD is entered so the
  // comparison sees the final edge counted on the last MEASURE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_cnt_a      <= '0;
      r_cnt_b      <= '0;
      r_out_cnt_a  <= '0;
      r_out_cnt_b  <= '0;
      r_resp_bit   <= 1'b0;
      r_resp_tie   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_ro_enable  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_SETTLE;
            r_timer     <= '0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_out_cnt_a <= '0;
            r_out_cnt_b <= '0;
            r_resp_bit  <= 1'b0;
            r_resp_tie  <= 1'b0;
            r_ro_enable <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (r_timer == SETTLE_LAST) begin
            r_state <= S_MEASURE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_MEASURE: begin
          if (w_rise_a && (r_cnt_a != CNT_MAX)) begin
            r_cnt_a <= r_cnt_a + CNT_W'(1);
          end
          if (w_rise_b && (r_cnt_b != CNT_MAX)) begin
            r_cnt_b <= r_cnt_b + CNT_W'(1);
          end
          if (r_timer == WINDOW_LAST) begin
            r_state     <= S_HOLD;
            r_timer     <= '0;
            r_ro_enable <= 1'b0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_HOLD: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_out_cnt_a  <= r_cnt_a;
            r_out_cnt_b  <= r_cnt_b;
            r_resp_bit   <= (r_cnt_a > r_cnt_b);
            r_resp_tie   <= (r_cnt_a == r_cnt_b);
          end else if (resp.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_ro_enable <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign ro_enable       = r_ro_enable;
  assign busy            = r_busy;
  assign resp.resp_valid = r_resp_valid;
  assign resp.resp_bit   = r_resp_bit;
  assign resp.resp_tie   = r_resp_tie;
  assign resp.cnt_a      = r_out_cnt_a;
  assign resp.cnt_b      = r_out_cnt_b;

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Scoreboard bench for ro_pair_comparator: a 16-bit instance and a 3-bit saturation instance.
`timescale 1ns/1ps
module tb_ro_pair_comparator;

  localparam int unsigned SETTLE_P = 4;
  localparam int unsigned WINDOW_P = 64;
  // start driven at a negedge -> first negedge with resp_valid high
  localparam int LAT = 1 + 1 + SETTLE_P + WINDOW_P;

  typedef struct {
    int valid_cyc;
    int a_lo;
    int a_hi;
    int b_lo;
    int b_hi;
    int bit_v;
    int tie_v;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start0, start1, ro_a, ro_b;
  logic en0, busy0, en1, busy1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   half_a   = 0;
  int   half_b   = 0;
  int   gen_ca   = 0;
  int   gen_cb   = 0;
  logic pv0      = 1'b0;
  logic pv1      = 1'b0;

  ro_pair_comparator_if #(.CNT_W(16)) if0 ();
  ro_pair_comparator_if #(.CNT_W(3))  if1 ();

  ro_pair_comparator #(.CNT_W(16), .SETTLE(SETTLE_P), .WINDOW(WINDOW_P)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .ro_a(ro_a), .ro_b(ro_b),
    .ro_enable(en0), .busy(busy0), .resp(if0)
  );

  ro_pair_comparator #(.CNT_W(3), .SETTLE(SETTLE_P), .WINDOW(WINDOW_P)) u_sat (
    .clk(clk), .rst(rst), .start(start1), .ro_a(ro_a), .ro_b(ro_b),
    .ro_enable(en1), .busy(busy1), .resp(if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_assert++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_assert++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input int a, input int b,
                     input int bv, input int tv);
    chk({tag, "_latency"}, cyc, e.valid_cyc);
    chk_rng({tag, "_cnt_a"}, a, e.a_lo, e.a_hi);
    chk_rng({tag, "_cnt_b"}, b, e.b_lo, e.b_hi);
    chk({tag, "_resp_bit"}, bv, e.bit_v);
    chk({tag, "_resp_tie"}, tv, e.tie_v);
  endtask

  // Ring oscillator models: toggle every half_x clk cycles, frozen when half_x is 0
  initial begin
    forever begin
      @(negedge clk);
      if (half_a != 0) begin
        gen_ca++;
        if (gen_ca >= half_a) begin ro_a = ~ro_a; gen_ca = 0; end
      end else gen_ca = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (half_b != 0) begin
        gen_cb++;
        if (gen_cb >= half_b) begin ro_b = ~ro_b; gen_cb = 0; end
      end else gen_cb = 0;
    end
  end

  // Monitors: compare each newly presented response against the scoreboard head
  always @(negedge clk) begin
    if (if0.resp_valid === 1'b1 && !pv0) begin
      if (q0.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL dut16_unexpected_resp: got resp_valid=1, expected no response (cycle %0d)", cyc);
      end else begin
        e0 = q0.pop_front();
        cmp("dut16", e0, int'(if0.cnt_a), int'(if0.cnt_b), int'(if0.resp_bit), int'(if0.resp_tie));
      end
    end
    pv0 <= (if0.resp_valid === 1'b1);
  end

  always @(negedge clk) begin
    if (if1.resp_valid === 1'b1 && !pv1) begin
      if (q1.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL dut3_unexpected_resp: got resp_valid=1, expected no response (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        cmp("dut3", e1, int'(if1.cnt_a), int'(if1.cnt_b), int'(if1.resp_bit), int'(if1.resp_tie));
      end
    end
    pv1 <= (if1.resp_valid === 1'b1);
  end

  task automatic push_exp(input bit which, input int alo, input int ahi, input int blo,
                          input int bhi, input int bv, input int tv);
    exp_t e;
    e.valid_cyc = cyc + LAT;
    e.a_lo = alo; e.a_hi = ahi; e.b_lo = blo; e.b_hi = bhi;
    e.bit_v = bv; e.tie_v = tv;
    if (which) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic start_run(input bit which, input int alo, input int ahi, input int blo,
                           input int bhi, input int bv, input int tv);
    @(negedge clk);
    push_exp(which, alo, ahi, blo, bhi, bv, tv);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_valid(input bit which, input int max_cyc);
    int k;
    k = 0;
    while (((which ? if1.resp_valid : if0.resp_valid) !== 1'b1) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cyc) begin
      n_assert++; n_fail++;
      $display("FAIL wait_valid_timeout: got no resp_valid, expected one within %0d cycles", max_cyc);
    end
  endtask

  task automatic accept(input bit which);
    @(negedge clk);
    if (which) if1.resp_ready = 1'b1; else if0.resp_ready = 1'b1;
    @(negedge clk);
    if1.resp_ready = 1'b0;
    if0.resp_ready = 1'b0;
    chk("accept_busy", which ? int'(busy1) : int'(busy0), 0);
    chk("accept_valid", which ? int'(if1.resp_valid) : int'(if0.resp_valid), 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    if0.resp_ready = 1'b0; if1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_en", int'(en0), 0);
    chk("rst_valid", int'(if0.resp_valid), 0);
    chk("rst_cnt_a", int'(if0.cnt_a), 0);
    chk("rst_tie", int'(if0.resp_tie), 0);
    chk("rst_sat_busy", int'(busy1), 0);
    rst = 1'b0;

    // Idle oscillators: tie, then stalled HOLD with ignored start pulses
    start_run(0, 0, 0, 0, 0, 0, 1);
    chk("settle_en", int'(en0), 1);
    chk("settle_busy", int'(busy0), 1);
    repeat (10) @(negedge clk);
    chk("measure_en", int'(en0), 1);
    wait_valid(0, 100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start0 = (i % 4 == 0);
      chk("hold_valid", int'(if0.resp_valid), 1);
      chk("hold_busy", int'(busy0), 1);
      chk("hold_en", int'(en0), 0);
      chk("hold_tie", int'(if0.resp_tie), 1);
    end
    @(negedge clk);
    if0.resp_ready = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    if0.resp_ready = 1'b0;
    start0 = 1'b0;
    chk("exit_busy", int'(busy0), 0);
    chk("exit_valid", int'(if0.resp_valid), 0);
    chk("idle_retain_tie", int'(if0.resp_tie), 1);
    @(negedge clk);
    chk("no_restart_busy", int'(busy0), 0);

    // A faster than B, then B faster than A
    half_a = 4; half_b = 8;
    start_run(0, 7, 9, 3, 5, 1, 0);
    wait_valid(0, 100);
    accept(0);
    chk_rng("idle_retain_cnt_a", int'(if0.cnt_a), 7, 9);
    half_a = 8; half_b = 4;
    start_run(0, 3, 5, 7, 9, 0, 0);
    wait_valid(0, 100);
    accept(0);

    // Reset in the middle of MEASURE must abort without a response
    start_run(0, 0, 0, 0, 0, 0, 0);
    repeat (SETTLE_P + 30 - 1) @(negedge clk);
    chk("pre_rst_busy", int'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_en", int'(en0), 0);
    chk("midrst_valid", int'(if0.resp_valid), 0);
    chk("midrst_cnt_a", int'(if0.cnt_a), 0);
    chk("midrst_cnt_b", int'(if0.cnt_b), 0);
    chk("midrst_bit", int'(if0.resp_bit), 0);
    repeat (80) @(negedge clk);
    chk("midrst_no_resp", int'(if0.resp_valid), 0);
    half_a = 4; half_b = 8;
    start_run(0, 7, 9, 3, 5, 1, 0);
    wait_valid(0, 100);
    accept(0);

    // Edges only during SETTLE are discarded
    half_a = 0; half_b = 0;
    @(negedge clk);
    ro_a = 1'b0; ro_b = 1'b0;
    repeat (5) @(negedge clk);
    push_exp(0, 0, 0, 0, 0, 0, 1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ro_a = 1'b1; ro_b = 1'b1;
    @(negedge clk);
    ro_a = 1'b0; ro_b = 1'b0;
    wait_valid(0, 100);
    accept(0);

    // 3-bit counter saturates at 7 instead of wrapping
    half_a = 2; half_b = 0;
    start_run(1, 7, 7, 0, 0, 1, 0);
    wait_valid(1, 100);
    accept(1);
    half_a = 0;

    repeat (5) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_assert++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
